// File: rtl/bombsquad_pkg.sv
// Shared constants for the bomb-squad game blocks: arming code, digit glyphs, blank display and
// checker state encodings, plus the LFSR-bits-to-code mapping.
package bombsquad_pkg;

  localparam logic [7:0]  START_CODE = 8'h10;

  localparam logic [3:0]  DIG0 = 4'b1110;
  localparam logic [3:0]  DIG1 = 4'b1101;
  localparam logic [3:0]  DIG2 = 4'b1011;
  localparam logic [3:0]  DIG3 = 4'b0111;

  localparam logic [15:0] BLANK = 16'hFFFF;

  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_LOAD    = 3'd1;
  localparam logic [2:0]  ST_SHOW    = 3'd2;
  localparam logic [2:0]  ST_COLLECT = 3'd3;
  localparam logic [2:0]  ST_RESULT  = 3'd4;

  function automatic logic [3:0] digit_map(input logic [1:0] f);
    logic [3:0] d;
    d = DIG0;
    case (f)
      2'd0: d = DIG0;
      2'd1: d = DIG1;
      2'd2: d = DIG2;
      2'd3: d = DIG3;
      default: d = DIG0;
    endcase
    return d;
  endfunction

  // Highest field becomes the first digit the player enters.
  function automatic logic [15:0] code_from_bits(input logic [7:0] b);
    return {digit_map(b[7:6]), digit_map(b[5:4]), digit_map(b[3:2]), digit_map(b[1:0])};
  endfunction

endpackage

// File: rtl/sequence_checker_if.sv
// Controller <-> sequence_checker signal bundle; master drives game inputs, slave is the checker.
interface sequence_checker_if;

  logic [7:0]  game_state;
  logic        one_sec;
  logic        button_next;
  logic [3:0]  response_in;
  logic [15:0] sequence_out;
  logic        collecting;
  logic [1:0]  digit_idx;
  logic        done;
  logic        pass;
  logic        fail;
  logic [3:0]  mismatch_mask;

  modport master (
    output game_state, one_sec, button_next, response_in,
    input  sequence_out, collecting, digit_idx, done, pass, fail, mismatch_mask
  );

  modport slave (
    input  game_state, one_sec, button_next, response_in,
    output sequence_out, collecting, digit_idx, done, pass, fail, mismatch_mask
  );

endinterface

// File: rtl/seq_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); never pauses, so player timing
// decides which value gets sampled as the next code.
module seq_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], feedback};
  end

endmodule

// File: rtl/sequence_checker.sv
// Generates a 4-digit one-hot-low code from the LFSR, shows it, then grades the player's entry.
// Optional SEQ_TIMEOUT_EN: COLLECT is bounded to TIMEOUT_SEC seconds; unentered digits fail.
//
// state   | meaning
// IDLE    | waiting for game_state == START_CODE
// LOAD    | latch code from LFSR, clear previous grade
// SHOW    | code on display, count SHOW_SEC seconds
// COLLECT | accept button_next presses, grade each digit
// RESULT  | grade held until game_state leaves START_CODE
module sequence_checker
  import bombsquad_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [1:0]  SHOW_SEC = 2'd3
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter logic [7:0]  TIMEOUT_SEC = 8'd30
`endif
) (
  input logic               clk,
  input logic               reset,
  sequence_checker_if.slave bus
);

  logic [15:0] lfsr;
  logic        unused_lfsr_hi;

  logic [2:0]  state;
  logic [7:0]  sec_cnt;
  logic [15:0] seq_q;
  logic [1:0]  idx_q;
  logic [3:0]  mask_q;
  logic        pass_q;
  logic        fail_q;
  logic        done_q;

  logic        armed;
  logic [3:0]  expected;
  logic [3:0]  press_mask;

  seq_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  // Only the low byte feeds the code; the upper bits just extend the period.
  assign unused_lfsr_hi = ^lfsr[15:8];

  assign armed = (bus.game_state == START_CODE);

  always_comb begin
    expected = seq_q[15:12];
    case (idx_q)
      2'd0:    expected = seq_q[15:12];
      2'd1:    expected = seq_q[11:8];
      2'd2:    expected = seq_q[7:4];
      2'd3:    expected = seq_q[3:0];
      default: expected = seq_q[15:12];
    endcase
  end

  // A non-one-hot-low response can never equal a code nibble, so it grades as wrong for free.
  always_comb begin
    press_mask = mask_q;
    if (bus.button_next && (bus.response_in != expected))
      press_mask[~idx_q] = 1'b1;
  end

`ifdef SEQ_TIMEOUT_EN
  logic [2:0] entered_n;
  logic [3:0] timeout_mask;

  assign entered_n    = {1'b0, idx_q} + {2'b00, bus.button_next};
  assign timeout_mask = press_mask | (4'b1111 >> entered_n);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      seq_q   <= BLANK;
      idx_q   <= 2'd0;
      sec_cnt <= 8'd0;
      mask_q  <= 4'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed) state <= ST_LOAD;
        end

        ST_LOAD: begin
          if (!armed) begin
            state <= ST_IDLE;
            seq_q <= BLANK;
          end else begin
            seq_q   <= code_from_bits(lfsr[7:0]);
            idx_q   <= 2'd0;
            sec_cnt <= 8'd0;
            mask_q  <= 4'd0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            state   <= ST_SHOW;
          end
        end

        ST_SHOW: begin
          if (!armed) begin
            state <= ST_IDLE;
            seq_q <= BLANK;
          end else if (bus.one_sec) begin
            if (sec_cnt + 8'd1 == {6'd0, SHOW_SEC}) begin
              sec_cnt <= 8'd0;
              state   <= ST_COLLECT;
            end else begin
              sec_cnt <= sec_cnt + 8'd1;
            end
          end
        end

        ST_COLLECT: begin
          if (!armed) begin
            state <= ST_IDLE;
            seq_q <= BLANK;
          end else if (bus.button_next && (idx_q == 2'd3)) begin
            // Fourth digit: idx stays at 3 so digit_idx never wraps back to the first digit.
            mask_q <= press_mask;
            pass_q <= (press_mask == 4'd0);
            fail_q <= (press_mask != 4'd0);
            done_q <= 1'b1;
            state  <= ST_RESULT;
          end else begin
            if (bus.button_next) begin
              mask_q <= press_mask;
              idx_q  <= idx_q + 2'd1;
            end
`ifdef SEQ_TIMEOUT_EN
            if (bus.one_sec) begin
              if (sec_cnt + 8'd1 == TIMEOUT_SEC) begin
                mask_q <= timeout_mask;
                pass_q <= 1'b0;
                fail_q <= 1'b1;
                done_q <= 1'b1;
                state  <= ST_RESULT;
              end else begin
                sec_cnt <= sec_cnt + 8'd1;
              end
            end
`endif
          end
        end

        ST_RESULT: begin
          if (!armed) begin
            state <= ST_IDLE;
            seq_q <= BLANK;
          end
        end

        default: begin
          state <= ST_IDLE;
          seq_q <= BLANK;
        end
      endcase
    end
  end

  assign bus.sequence_out  = seq_q;
  assign bus.collecting    = (state == ST_COLLECT);
  assign bus.digit_idx     = idx_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail          = fail_q;
  assign bus.mismatch_mask = mask_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed rounds with literal expectations plus randomized play,
// all outputs compared every cycle against a game-rule model. Honours SEQ_TIMEOUT_EN.
module tb_sequence_checker;
  import bombsquad_pkg::*;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          SHOW_N = 3;
`ifdef SEQ_TIMEOUT_EN
  localparam int          TO_N   = 5;
`endif

  localparam int P_IDLE = 0, P_LOAD = 1, P_SHOW = 2, P_ENTRY = 3, P_RESULT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sequence_checker_if bus();

`ifdef SEQ_TIMEOUT_EN
  sequence_checker #(.SEED(SEED), .SHOW_SEC(2'd3), .TIMEOUT_SEC(8'd5)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
`else
  sequence_checker #(.SEED(SEED), .SHOW_SEC(2'd3)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
`endif

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;
  int          m_secs;
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  logic [15:0] m_code;
  logic [15:0] m_shown;
  logic [3:0]  m_entries[$];
  bit          m_timed_out, m_pass, m_fail, m_done, m_armed;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 16'h1;
    return ((v << 1) | {15'd0, fb}) & 16'hFFFF;
  endfunction

  function automatic logic [15:0] make_code(input logic [15:0] v);
    logic [15:0] c;
    int f;
    c = 16'h0;
    for (int i = 0; i < 4; i++) begin
      f = int'((v >> (6 - 2 * i)) & 16'h3);
      c = c | (16'((4'hF & ~(4'd1 << f))) << (12 - 4 * i));
    end
    return c;
  endfunction

  function automatic logic [3:0] mask_of();
    logic [3:0] m;
    logic [3:0] want;
    m = 4'd0;
    for (int i = 0; i < 4; i++) begin
      want = 4'((m_code >> (12 - 4 * i)) & 16'hF);
      if (i < m_entries.size()) begin
        if (m_entries[i] != want) m[3 - i] = 1'b1;
      end else if (m_timed_out) begin
        m[3 - i] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [1:0] idx_of();
    return (m_entries.size() >= 3) ? 2'd3 : 2'(m_entries.size());
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_IDLE; m_lfsr = SEED; m_shown = 16'hFFFF; m_code = 16'hFFFF;
      m_entries.delete(); m_timed_out = 0; m_pass = 0; m_fail = 0; m_done = 0; m_secs = 0;
    end else begin
      m_prev  = m_lfsr;
      m_lfsr  = lfsr_next(m_lfsr);
      m_done  = 0;
      m_armed = (bus.game_state == START_CODE);
      case (m_phase)
        P_IDLE: if (m_armed) m_phase = P_LOAD;
        P_LOAD: begin
          if (!m_armed) begin
            m_phase = P_IDLE; m_shown = 16'hFFFF;
          end else begin
            m_code = make_code(m_prev); m_shown = m_code; m_entries.delete();
            m_timed_out = 0; m_pass = 0; m_fail = 0; m_secs = 0; m_phase = P_SHOW;
          end
        end
        P_SHOW: begin
          if (!m_armed) begin
            m_phase = P_IDLE; m_shown = 16'hFFFF;
          end else if (bus.one_sec) begin
            m_secs++;
            if (m_secs == SHOW_N) begin m_secs = 0; m_phase = P_ENTRY; end
          end
        end
        P_ENTRY: begin
          if (!m_armed) begin
            m_phase = P_IDLE; m_shown = 16'hFFFF;
          end else begin
            if (bus.button_next) m_entries.push_back(bus.response_in);
            if (m_entries.size() == 4) begin
              m_pass = (mask_of() == 4'd0); m_fail = !m_pass; m_done = 1; m_phase = P_RESULT;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (bus.one_sec) begin
              m_secs++;
              if (m_secs == TO_N) begin
                m_timed_out = 1; m_pass = 0; m_fail = 1; m_done = 1; m_phase = P_RESULT;
              end
            end
`endif
          end
        end
        P_RESULT: if (!m_armed) begin m_phase = P_IDLE; m_shown = 16'hFFFF; end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("sequence_out",  bus.sequence_out, m_shown);
      check("collecting",    16'(bus.collecting), 16'(m_phase == P_ENTRY));
      check("digit_idx",     16'(bus.digit_idx), 16'(idx_of()));
      check("done",          16'(bus.done), 16'(m_done));
      check("pass",          16'(bus.pass), 16'(m_pass));
      check("fail",          16'(bus.fail), 16'(m_fail));
      check("mismatch_mask", 16'(bus.mismatch_mask), 16'(mask_of()));
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] s;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sec();
    bus.one_sec = 1'b1;
    tick();
    bus.one_sec = 1'b0;
  endtask

  task automatic press(input logic [3:0] r);
    bus.button_next = 1'b1;
    bus.response_in = r;
    tick();
    bus.button_next = 1'b0;
  endtask

  task automatic new_round();
    bus.game_state = 8'h00;
    tick();
    bus.game_state = START_CODE;
    tick();
    tick();
    repeat (SHOW_N) pulse_sec();
    s = bus.sequence_out;
  endtask

  initial begin
    bus.game_state  = 8'h00;
    bus.one_sec     = 1'b0;
    bus.button_next = 1'b0;
    bus.response_in = 4'hF;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();

    check("rst_sequence_out", bus.sequence_out, 16'hFFFF);
    check("rst_done",  16'(bus.done), 16'd0);
    check("rst_pass",  16'(bus.pass), 16'd0);
    check("rst_fail",  16'(bus.fail), 16'd0);
    check("rst_mask",  16'(bus.mismatch_mask), 16'd0);
    check("rst_idx",   16'(bus.digit_idx), 16'd0);

    // Arm on the first edge after reset: LOAD samples the LFSR one step past the seed.
    bus.game_state = START_CODE;
    reset = 1'b1;
    tick();
    check("load_not_collecting", 16'(bus.collecting), 16'd0);
    tick();
    check("first_code", bus.sequence_out, 16'h7EE7);

    // Press during SHOW is ignored.
    pulse_sec();
    pulse_sec();
    press(4'b1110);
    check("show_press_idx", 16'(bus.digit_idx), 16'd0);
    check("show_press_not_collecting", 16'(bus.collecting), 16'd0);
    pulse_sec();
    check("collecting_after_show", 16'(bus.collecting), 16'd1);
    s = bus.sequence_out;

    press(s[15:12]); press(s[11:8]); press(s[7:4]); press(s[3:0]);
    check("all_right_done", 16'(bus.done), 16'd1);
    check("all_right_pass", 16'(bus.pass), 16'd1);
    check("all_right_fail", 16'(bus.fail), 16'd0);
    check("all_right_mask", 16'(bus.mismatch_mask), 16'd0);
    tick();
    check("done_one_cycle", 16'(bus.done), 16'd0);
    check("pass_held", 16'(bus.pass), 16'd1);

    new_round();
    press(s[15:12]); press(4'b0000); press(s[7:4]); press(s[3:0]);
    check("second_wrong_done", 16'(bus.done), 16'd1);
    check("second_wrong_fail", 16'(bus.fail), 16'd1);
    check("second_wrong_pass", 16'(bus.pass), 16'd0);
    check("second_wrong_mask", 16'(bus.mismatch_mask), 16'h4);

    new_round();
    press(s[15:12]); press(s[11:8]);
    bus.game_state = 8'h00;
    tick();
    check("abort_seq",  bus.sequence_out, 16'hFFFF);
    check("abort_coll", 16'(bus.collecting), 16'd0);
    check("abort_done", 16'(bus.done), 16'd0);
    check("abort_pass", 16'(bus.pass), 16'd0);
    check("abort_fail", 16'(bus.fail), 16'd0);
    tick();
    check("abort_no_late_done", 16'(bus.done), 16'd0);

    new_round();
    press(s[15:12]);
    reset = 1'b0;
    #2;
    check("midreset_seq",  bus.sequence_out, 16'hFFFF);
    check("midreset_coll", 16'(bus.collecting), 16'd0);
    check("midreset_done", 16'(bus.done), 16'd0);
    check("midreset_pass", 16'(bus.pass), 16'd0);
    check("midreset_fail", 16'(bus.fail), 16'd0);
    check("midreset_idx",  16'(bus.digit_idx), 16'd0);
    tick();
    reset = 1'b1;

`ifdef SEQ_TIMEOUT_EN
    new_round();
    press(s[15:12]);
    repeat (TO_N) pulse_sec();
    check("timeout_done", 16'(bus.done), 16'd1);
    check("timeout_fail", 16'(bus.fail), 16'd1);
    check("timeout_mask", 16'(bus.mismatch_mask), 16'h7);
`endif

    // Randomized play.
    bus.game_state = START_CODE;
    for (int c = 0; c < 4000; c++) begin
      if (bus.game_state == START_CODE) begin
        if (m_phase == P_RESULT && $urandom_range(0, 3) == 0)
          bus.game_state = 8'h00;
        else if ($urandom_range(0, 199) == 0)
          bus.game_state = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.game_state = START_CODE;
      end
      bus.one_sec     = ($urandom_range(0, 5) == 0);
      bus.button_next = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0 && m_entries.size() < 4)
        bus.response_in = 4'((m_code >> (12 - 4 * m_entries.size())) & 16'hF);
      else
        bus.response_in = 4'($urandom_range(0, 15));
      tick();
    end
    bus.one_sec     = 1'b0;
    bus.button_next = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
